// File: rtl/vscale_sim_ctrl.sv
// Simulation run controller: sequences core reset release, counts run cycles
// and turns per-core tohost status writes or a watchdog expiry into a sticky verdict.
module vscale_sim_ctrl #(
  parameter int N_CORES        = 1,
  parameter int XLEN           = 32,
  parameter int RESET_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [N_CORES-1:0]      core_reset,
  input  logic [N_CORES-1:0]      tohost_wen,
  input  logic [N_CORES*XLEN-1:0] tohost_wdata,
  output logic [CNT_W-1:0]        cycle_count,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [N_CORES-1:0]      fail_vec,
  output logic [XLEN-2:0]         fail_code
);

  typedef enum logic [2:0] {S_HOLD, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [N_CORES-1:0]   passed_q;
  logic [N_CORES-1:0]   core_reset_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 done_q, pass_q, timeout_q;
  logic [N_CORES-1:0]   fail_vec_q;
  logic [XLEN-2:0]      fail_code_q;

  // Per-core status decode of this cycle's tohost write.
  logic [N_CORES-1:0]              lane_pass, lane_fail;
  logic [N_CORES-1:0][XLEN-2:0]    lane_code;

  for (genvar i = 0; i < N_CORES; i++) begin : g_lane
    logic [XLEN-1:0] d;
    assign d            = tohost_wdata[i*XLEN +: XLEN];
    assign lane_pass[i] = tohost_wen[i] && (d == XLEN'(1));
    assign lane_fail[i] = tohost_wen[i] && d[0] && (d[XLEN-1:1] != '0);
    assign lane_code[i] = d[XLEN-1:1];
  end

  // Lowest-index failing core supplies the code.
  logic [XLEN-2:0] first_code;
  always_comb begin
    first_code = '0;
    for (int i = N_CORES - 1; i >= 0; i--)
      if (lane_fail[i]) first_code = lane_code[i];
  end

  logic any_fail, all_pass, wd_fire, hold_end;
  assign any_fail = |lane_fail;
  assign all_pass = &(passed_q | lane_pass);
  assign wd_fire  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  assign hold_end = (RESET_CYCLES == 0) || (hold_q == HOLD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HOLD;
      hold_q       <= '0;
      passed_q     <= '0;
      core_reset_q <= '1;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_vec_q   <= '0;
      fail_code_q  <= '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          hold_q <= hold_q + 1'b1;
          if (hold_end) begin
            state_q      <= S_RUN;
            core_reset_q <= '0;
          end
        end
        S_RUN: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          passed_q <= passed_q | lane_pass;
          // Fail beats pass, pass beats the watchdog on the same edge.
          if (any_fail) begin
            state_q      <= S_FAIL;
            fail_vec_q   <= fail_vec_q | lane_fail;
            fail_code_q  <= first_code;
            done_q       <= 1'b1;
            core_reset_q <= '1;
          end else if (all_pass) begin
            state_q      <= S_PASS;
            done_q       <= 1'b1;
            pass_q       <= 1'b1;
            core_reset_q <= '1;
          end else if (wd_fire) begin
            state_q      <= S_TIMEOUT;
            done_q       <= 1'b1;
            timeout_q    <= 1'b1;
            core_reset_q <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign cycle_count = cnt_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_vec    = fail_vec_q;
  assign fail_code   = fail_code_q;

endmodule

// File: tb/tb_vscale_sim_ctrl.sv
// Randomized bench for vscale_sim_ctrl: verdicts predicted from write schedules.
module tb_vscale_sim_ctrl;
  localparam int N  = 2;
  localparam int XL = 32;
  localparam int RC = 10;
  localparam int TO = 200;
  localparam int K_PASS = 0, K_FAIL = 1, K_TO = 2;
  localparam int BIG = 1 << 30;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      core_reset, wen, fail_vec;
  logic [N*XL-1:0]   wdata;
  logic [31:0]       cycle_count;
  logic              done, pass, timeout;
  logic [XL-2:0]     fail_code;

  logic              rst_z;
  logic [0:0]        core_reset_z, wen_z, fail_vec_z;
  logic [XL-1:0]     wdata_z;
  logic [31:0]       cycle_count_z;
  logic              done_z, pass_z, timeout_z;
  logic [XL-2:0]     fail_code_z;

  always #5 clk = ~clk;

  vscale_sim_ctrl #(.N_CORES(N), .XLEN(XL), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(32)) u_dut (
    .clk(clk), .reset(rst_n), .core_reset(core_reset), .tohost_wen(wen), .tohost_wdata(wdata),
    .cycle_count(cycle_count), .done(done), .pass(pass), .timeout(timeout),
    .fail_vec(fail_vec), .fail_code(fail_code));

  vscale_sim_ctrl #(.N_CORES(1), .XLEN(XL), .RESET_CYCLES(0), .TIMEOUT_CYCLES(0), .CNT_W(32)) u_dut_z (
    .clk(clk), .reset(rst_z), .core_reset(core_reset_z), .tohost_wen(wen_z), .tohost_wdata(wdata_z),
    .cycle_count(cycle_count_z), .done(done_z), .pass(pass_z), .timeout(timeout_z),
    .fail_vec(fail_vec_z), .fail_code(fail_code_z));

  int n_chk = 0, n_fail = 0;

  // Write schedule, indexed by run cycle (cycle_count value at the sampling edge).
  bit          wv   [0:TO-1][0:N-1];
  logic [31:0] wdat [0:TO-1][0:N-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen(input int kind);
    logic [31:0] d;
    case (kind)
      0: d = 32'h1;
      1: begin d = ($urandom << 1) | 32'h1; if (d == 32'h1) d = 32'h3; end
      default: d = $urandom & 32'hFFFF_FFFE;
    endcase
    return d;
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < TO; c++)
      for (int i = 0; i < N; i++) begin wv[c][i] = 1'b0; wdat[c][i] = '0; end
  endtask

  task automatic put(input int c, input int i, input logic [31:0] d);
    wv[c][i] = 1'b1; wdat[c][i] = d;
  endtask

  // Per-mille probabilities for fail / pass / non-status writes.
  task automatic rand_sched(input int pf, input int pp, input int pi);
    int r;
    clear_sched();
    for (int c = 0; c < TO; c++)
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 999);
        if (r < pf) put(c, i, gen(1));
        else if (r < pf + pp) put(c, i, gen(0));
        else if (r < pf + pp + pi) put(c, i, gen(2));
      end
  endtask

  // Verdict = earliest of first fail, first time every core has passed, watchdog.
  task automatic model(output int v, output int kind, output logic [N-1:0] fv, output logic [XL-2:0] fc);
    int fail_at, pass_at;
    bit seen [0:N-1];
    bit all;
    fail_at = BIG; pass_at = BIG; fv = '0; fc = '0;
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int c = 0; c < TO; c++) begin
      for (int i = 0; i < N; i++)
        if (wv[c][i]) begin
          if (wdat[c][i] == 32'h1) seen[i] = 1'b1;
          if (wdat[c][i][0] && (wdat[c][i] >> 1) != 0 && fail_at == BIG) fail_at = c;
        end
      all = 1'b1;
      for (int i = 0; i < N; i++) all = all & seen[i];
      if (all && pass_at == BIG) pass_at = c;
    end
    v = TO - 1; kind = K_TO;
    if (pass_at <= v) begin v = pass_at; kind = K_PASS; end
    if (fail_at <= v) begin v = fail_at; kind = K_FAIL; end
    if (kind == K_FAIL)
      for (int i = N - 1; i >= 0; i--)
        if (wv[v][i] && wdat[v][i][0] && (wdat[v][i] >> 1) != 0) begin
          fv[i] = 1'b1; fc = wdat[v][i][31:1];
        end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_crst"}, core_reset, {N{1'b1}});
    chk({tag, "_cnt"},  cycle_count, 0);
    chk({tag, "_done"}, {done, pass, timeout}, 3'b000);
    chk({tag, "_fvec"}, fail_vec, 0);
    chk({tag, "_fcode"}, fail_code, 0);
  endtask

  // Runs the loaded schedule; abort_at >= 0 asserts reset at that run cycle.
  task automatic run_sched(input string tag, input int abort_at);
    int v, kind;
    logic [N-1:0]  fv;
    logic [XL-2:0] fc;
    model(v, kind, fv, fc);
    rst_n = 1'b0; wen = '0; wdata = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_vals({tag, "_rst"});
    rst_n = 1'b1;
    for (int h = 0; h < RC; h++) begin
      for (int i = 0; i < N; i++) begin
        wen[i] = 1'($urandom_range(0, 1)); wdata[i*XL +: XL] = gen($urandom_range(0, 2));
      end
      @(negedge clk);
      chk({tag, "_hold_crst"}, core_reset, (h == RC - 1) ? '0 : {N{1'b1}});
      chk({tag, "_hold_cnt"}, {done, cycle_count}, 0);
    end
    for (int c = 0; c <= v + 3; c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0; #1;
        chk_reset_vals({tag, "_abort"});
        wen = '0;
        return;
      end
      for (int i = 0; i < N; i++)
        if (c < TO && c <= v) begin
          wen[i] = wv[c][i]; wdata[i*XL +: XL] = wdat[c][i];
        end else begin
          wen[i] = 1'b1; wdata[i*XL +: XL] = gen($urandom_range(0, 1));
        end
      @(negedge clk);
      if (c < v) begin
        chk({tag, "_cnt"}, cycle_count, c + 1);
        chk({tag, "_flags"}, {done, pass, timeout, fail_vec, core_reset}, 0);
      end else begin
        chk({tag, "_tcnt"}, cycle_count, v + 1);
        chk({tag, "_tflags"}, {done, pass, timeout}, {1'b1, kind == K_PASS, kind == K_TO});
        chk({tag, "_fvec"}, fail_vec, fv);
        chk({tag, "_fcode"}, fail_code, fc);
        chk({tag, "_tcrst"}, core_reset, {N{1'b1}});
      end
    end
    wen = '0;
  endtask

  initial begin
    rst_n = 1'b0; rst_z = 1'b0; wen = '0; wdata = '0; wen_z = '0; wdata_z = '0;

    clear_sched();                                   run_sched("idle", -1);
    clear_sched(); put(20, 0, 32'h1); put(40, 1, 32'h1); run_sched("pass2", -1);
    clear_sched(); put(15, 0, 32'h5); put(15, 1, 32'h9); run_sched("dualfail", -1);
    clear_sched(); put(50, 0, 32'h7);                run_sched("fail7", -1);
    clear_sched(); put(10, 0, 32'h1); put(TO-1, 1, 32'h1); run_sched("passedge", -1);
    clear_sched(); put(5, 0, 32'h1); put(30, 0, 32'h3); put(30, 1, 32'h1); run_sched("failprio", -1);
    rand_sched(0, 0, 300);                           run_sched("ignore", -1);
    rand_sched(0, 30, 100);                          run_sched("abort", 30);
    for (int s = 0; s < 8; s++) begin
      rand_sched((s % 3 == 0) ? 0 : 3, 10 + 5 * s, 200);
      run_sched($sformatf("rnd%0d", s), -1);
    end

    // Zero-hold build with the watchdog disabled.
    rst_z = 1'b0; @(negedge clk); rst_z = 1'b1;
    @(negedge clk);
    chk("z_crst", core_reset_z, 1'b0);
    chk("z_cnt0", cycle_count_z, 0);
    repeat (250) @(negedge clk);
    chk("z_nowd", {done_z, timeout_z, cycle_count_z}, 250);
    wen_z = 1'b1; wdata_z = 32'h7;
    @(negedge clk);
    wen_z = 1'b0;
    chk("z_fail", {done_z, pass_z, fail_vec_z, cycle_count_z}, {1'b1, 1'b0, 1'b1, 32'd251});
    chk("z_code", fail_code_z, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
